clk_div_prog: RTL and testbench

Parametrised, multi-channel programmable clock divider for the digital-clock datapath. Each of NCH channels divides clk by a runtime-loadable integer divisor and produces a divided clock-level output (high for ceil(D/2) cycles) and a one-cycle tick marking each rising edge of that output. Divisor updates are glitch-free: they are held pending and take effect only at a period boundary. It replaces fixed divide-by-N blocks feeding the second/minute counters and display multiplexing.

---
 rtl/clk_div_prog_if.sv | 19 +
 rtl/clk_div_prog.sv | 98 +++++++++
 tb/tb_clk_div_prog.sv | 112 +++++++++++
 3 files changed

// File: rtl/clk_div_prog_if.sv
// clk_div_prog_if: divisor-write bus between a controller and clk_div_prog.
//   div_wr  : one-cycle write strobe (master -> slave)
//   div_sel : target channel of the write (master -> slave)
//   div_val : new divisor (master -> slave)
//   div_ack : write accepted, one-cycle pulse (slave -> master)
//   div_err : write rejected, one-cycle pulse (slave -> master)
interface clk_div_prog_if #(
    parameter int WIDTH = 8,
    parameter int SELW  = 1
);
    logic             div_wr;
    logic [SELW-1:0]  div_sel;
    logic [WIDTH-1:0] div_val;
    logic             div_ack;
    logic             div_err;

    modport master (output div_wr, div_sel, div_val, input div_ack, div_err);
    modport slave  (input div_wr, div_sel, div_val, output div_ack, div_err);
endinterface

// File: rtl/clk_div_prog.sv
// clk_div_prog: multi-channel programmable clock divider with glitch-free divisor updates.
//   clk     : system clock, rising edge
//   rst     : asynchronous, active-low reset
//   en      : per-channel run enable
//   sync    : phase-align strobe, present only when CLK_DIV_SYNC_EN is defined
//   bus     : divisor-write interface (clk_div_prog_if.slave)
//   out_clk : divided clock level per channel, high for D - floor(D/2) cycles
//   tick    : one-cycle pulse on each out_clk rising edge
// Optional feature macro: CLK_DIV_SYNC_EN.
module clk_div_prog #(
    parameter int WIDTH       = 8,
    parameter int NCH         = 2,
    parameter int SELW        = 1,
    parameter int DEFAULT_DIV = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NCH-1:0]   en,
`ifdef CLK_DIV_SYNC_EN
    input  logic             sync,
`endif
    clk_div_prog_if.slave    bus,
    output logic [NCH-1:0]   out_clk,
    output logic [NCH-1:0]   tick
);
    logic [WIDTH-1:0] d_q   [NCH];
    logic [WIDTH-1:0] d_d   [NCH];
    logic [WIDTH-1:0] cnt_q [NCH];
    logic [WIDTH-1:0] cnt_d [NCH];
    logic [WIDTH-1:0] p_q   [NCH];
    logic [WIDTH-1:0] p_d   [NCH];
    logic [NCH-1:0]   pv_q, pv_d;
    logic [NCH-1:0]   out_q, out_d;
    logic [NCH-1:0]   tick_q, tick_d;
    logic [NCH-1:0]   hit, wrap, run, apply;
    logic             ack_q, ack_d;
    logic             err_q, err_d;
    logic             wr_ok;
    logic             sync_i;

`ifdef CLK_DIV_SYNC_EN
    assign sync_i = sync;
`else
    assign sync_i = 1'b0;
`endif

    always_comb begin
        wr_ok = bus.div_wr && (bus.div_val != '0) && (32'(bus.div_sel) < 32'(NCH));
        ack_d = wr_ok;
        err_d = bus.div_wr && !wr_ok;
        for (int i = 0; i < NCH; i++) begin
            hit[i]   = wr_ok && (32'(bus.div_sel) == 32'(i));
            run[i]   = en[i] && !sync_i;
            wrap[i]  = cnt_q[i] == d_q[i] - WIDTH'(1);
            // A pending divisor may only land at a period boundary or while the channel is idle.
            apply[i] = !run[i] || wrap[i];
            d_d[i]   = (apply[i] && pv_q[i]) ? p_q[i] : d_q[i];
            // The wrap consumes the prior pending value; a same-edge write re-arms it.
            pv_d[i]  = hit[i] || (pv_q[i] && !apply[i]);
            p_d[i]   = hit[i] ? bus.div_val : p_q[i];
            // Idle channels park at D-1 so the first enabled edge wraps to 0 and rises.
            cnt_d[i] = !run[i] ? d_d[i] - WIDTH'(1) : wrap[i] ? '0 : cnt_q[i] + WIDTH'(1);
            out_d[i] = run[i] && (cnt_d[i] < d_d[i] - (d_d[i] >> 1));
            tick_d[i] = run[i] && (cnt_d[i] == '0);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NCH; i++) begin
                d_q[i]   <= WIDTH'(DEFAULT_DIV);
                cnt_q[i] <= WIDTH'(DEFAULT_DIV - 1);
                p_q[i]   <= '0;
            end
            pv_q   <= '0;
            out_q  <= '0;
            tick_q <= '0;
            ack_q  <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                d_q[i]   <= d_d[i];
                cnt_q[i] <= cnt_d[i];
                p_q[i]   <= p_d[i];
            end
            pv_q   <= pv_d;
            out_q  <= out_d;
            tick_q <= tick_d;
            ack_q  <= ack_d;
            err_q  <= err_d;
        end
    end

    assign out_clk     = out_q;
    assign tick        = tick_q;
    assign bus.div_ack = ack_q;
    assign bus.div_err = err_q;
endmodule

// File: tb/tb_clk_div_prog.sv
// tb_clk_div_prog: directed self-checking bench for clk_div_prog (NCH=2, SELW=2, WIDTH=8).
module tb_clk_div_prog;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [1:0] en  = 2'b01;
    logic       sync = 1'b0;
    logic [1:0] out_clk, tick;
    int checks = 0;
    int errors = 0;

    clk_div_prog_if #(.WIDTH(8), .SELW(2)) bif ();

    clk_div_prog #(.WIDTH(8), .NCH(2), .SELW(2), .DEFAULT_DIV(6)) dut (
        .clk(clk),
        .rst(rst),
        .en(en),
`ifdef CLK_DIV_SYNC_EN
        .sync(sync),
`endif
        .bus(bif.slave),
        .out_clk(out_clk),
        .tick(tick)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input string tag, input logic [1:0] eo, input logic [1:0] et,
                        input logic ea, input logic ee);
        @(negedge clk);
        chk({tag, "_out"}, 8'(out_clk), 8'(eo));
        chk({tag, "_tick"}, 8'(tick), 8'(et));
        chk({tag, "_ack"}, 8'(bif.div_ack), 8'(ea));
        chk({tag, "_err"}, 8'(bif.div_err), 8'(ee));
    endtask

    // Expected bit vectors are listed first-edge-first (MSB = first edge).
    task automatic run(input string tag, input int n, input logic [31:0] o0, input logic [31:0] o1,
                       input logic [31:0] t0, input logic [31:0] t1);
        for (int j = 0; j < n; j++)
            step($sformatf("%s%0d", tag, j), {o1[n-1-j], o0[n-1-j]}, {t1[n-1-j], t0[n-1-j]}, 1'b0, 1'b0);
    endtask

    initial begin
        bif.div_wr  = 1'b0;
        bif.div_sel = '0;
        bif.div_val = '0;
        @(negedge clk);
        step("rst", 2'b00, 2'b00, 1'b0, 1'b0);
        rst = 1'b1;
        run("div6_", 13, 32'b1110001110001, 32'b0, 32'b1000001000001, 32'b0);
        step("e14", 2'b01, 2'b00, 1'b0, 1'b0);
        bif.div_wr = 1'b1; bif.div_sel = 2'd0; bif.div_val = 8'd5;
        step("wr5", 2'b01, 2'b00, 1'b1, 1'b0);
        bif.div_wr = 1'b0;
        run("old_then5_", 9, 32'b000111001, 32'b0, 32'b000100001, 32'b0);
        bif.div_wr = 1'b1; bif.div_sel = 2'd0; bif.div_val = 8'd0;
        step("err_zero", 2'b01, 2'b00, 1'b0, 1'b1);
        bif.div_sel = 2'd3; bif.div_val = 8'd4;
        step("err_sel", 2'b01, 2'b00, 1'b0, 1'b1);
        bif.div_wr = 1'b0;
        run("after_err_", 3, 32'b001, 32'b0, 32'b001, 32'b0);
        bif.div_wr = 1'b1; bif.div_sel = 2'd1; bif.div_val = 8'd1;
        step("wr1", 2'b01, 2'b00, 1'b1, 1'b0);
        bif.div_wr = 1'b0; en = 2'b11;
        run("d1_", 3, 32'b100, 32'b111, 32'b000, 32'b111);
        bif.div_wr = 1'b1; bif.div_sel = 2'd1; bif.div_val = 8'd2;
        step("wr2", 2'b11, 2'b11, 1'b1, 1'b0);
        bif.div_wr = 1'b0;
        run("d2_", 4, 32'b1100, 32'b1010, 32'b0000, 32'b1010);
        en = 2'b01;
        bif.div_wr = 1'b1; bif.div_sel = 2'd1; bif.div_val = 8'd7;
        step("wr7", 2'b01, 2'b01, 1'b1, 1'b0);
        bif.div_val = 8'd4;
        step("wr4", 2'b01, 2'b00, 1'b1, 1'b0);
        bif.div_wr = 1'b0;
        step("dis", 2'b01, 2'b00, 1'b0, 1'b0);
        en = 2'b11;
        run("d4_", 5, 32'b00111, 32'b11001, 32'b00100, 32'b10001);
        en = 2'b01;
        step("en_fall", 2'b00, 2'b00, 1'b0, 1'b0);
        en = 2'b11;
        step("re_en", 2'b10, 2'b10, 1'b0, 1'b0);
        rst = 1'b0;
        #1;
        chk("async_rst_out", 8'(out_clk), 8'h00);
        chk("async_rst_tick", 8'(tick), 8'h00);
        @(negedge clk);
        rst = 1'b1; en = 2'b01;
        run("post_rst_", 7, 32'b1110001, 32'b0, 32'b1000001, 32'b0);
`ifdef CLK_DIV_SYNC_EN
        en = 2'b00;
        bif.div_wr = 1'b1; bif.div_sel = 2'd0; bif.div_val = 8'd4;
        step("wr4s", 2'b00, 2'b00, 1'b1, 1'b0);
        bif.div_wr = 1'b0; en = 2'b11;
        repeat (7) @(negedge clk);
        sync = 1'b1;
        step("sync", 2'b00, 2'b00, 1'b0, 1'b0);
        sync = 1'b0;
        step("sync_rise", 2'b11, 2'b11, 1'b0, 1'b0);
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
